// File: rtl/pd_phy_pkg.sv
// Shared PD PHY definitions: SOP type codes, TX scheduler state encodings and
// the completion-pulse bundle used by the scheduler and the packet editor.
package pd_phy_pkg;

   localparam int SOP_W = 3;

   typedef enum logic [SOP_W-1:0] {
      SOP_TYPE_SOP         = 3'd0,
      SOP_TYPE_SOP_P       = 3'd1,
      SOP_TYPE_SOP_PP      = 3'd2,
      SOP_TYPE_HARD_RESET  = 3'd3,
      SOP_TYPE_CABLE_RESET = 3'd4
   } sop_type_e;

   typedef enum logic [2:0] {
      TX_IDLE      = 3'd0,
      TX_GAP       = 3'd1,
      TX_SEND      = 3'd2,
      TX_BIST      = 3'd3,
      TX_BIST_STOP = 3'd4
   } tx_state_e;

   typedef struct packed {
      logic ack;
      logic discard;
      logic tx_done;
      logic hr_done;
      logic cr_done;
   } tx_pulse_t;

   function automatic logic is_reset_type(input logic [SOP_W-1:0] t);
      return (t == SOP_TYPE_HARD_RESET) || (t == SOP_TYPE_CABLE_RESET);
   endfunction

   // Completion pulse that matches the type that was on the wire.
   function automatic tx_pulse_t done_pulse(input logic [SOP_W-1:0] t);
      tx_pulse_t p;
      p = '0;
      case (t)
         SOP_TYPE_HARD_RESET:  p.hr_done = 1'b1;
         SOP_TYPE_CABLE_RESET: p.cr_done = 1'b1;
         default:              p.tx_done = 1'b1;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/phy_tx_scheduler_if.sv
// Protocol-layer / encoder / editor signals of the PHY TX scheduler.
// slave = scheduler view, master = environment (protocol layer, encoder, RX) view.
interface phy_tx_scheduler_if;
   import pd_phy_pkg::*;

   logic             pl2phy_tx_req;
   logic [SOP_W-1:0] pl2phy_tx_sop_type;
   logic             pl2phy_hard_reset_req;
   logic             pl2phy_cable_reset_req;
   logic             pl2phy_bist_carrier_req;
   logic             phy_rx_busy;
   logic             phy_bmc_encoder_data_done;
   logic             phy_bmc_encoder_hold_lowbmc_done;

   logic             phy_tx_packet_en;
   logic [SOP_W-1:0] phy_tx_packet_type;
   logic             phy_tx_bist_en;
   logic             phy2pl_tx_ack;
   logic             phy2pl_tx_done;
   logic             phy2pl_tx_discard;
   logic             phy2pl_hard_reset_done;
   logic             phy2pl_cable_reset_done;
   logic             phy_tx_busy;

   modport slave (
      input  pl2phy_tx_req, pl2phy_tx_sop_type, pl2phy_hard_reset_req,
             pl2phy_cable_reset_req, pl2phy_bist_carrier_req, phy_rx_busy,
             phy_bmc_encoder_data_done, phy_bmc_encoder_hold_lowbmc_done,
      output phy_tx_packet_en, phy_tx_packet_type, phy_tx_bist_en,
             phy2pl_tx_ack, phy2pl_tx_done, phy2pl_tx_discard,
             phy2pl_hard_reset_done, phy2pl_cable_reset_done, phy_tx_busy
   );

   modport master (
      output pl2phy_tx_req, pl2phy_tx_sop_type, pl2phy_hard_reset_req,
             pl2phy_cable_reset_req, pl2phy_bist_carrier_req, phy_rx_busy,
             phy_bmc_encoder_data_done, phy_bmc_encoder_hold_lowbmc_done,
      input  phy_tx_packet_en, phy_tx_packet_type, phy_tx_bist_en,
             phy2pl_tx_ack, phy2pl_tx_done, phy2pl_tx_discard,
             phy2pl_hard_reset_done, phy2pl_cable_reset_done, phy_tx_busy
   );

endinterface

// File: rtl/phy_tx_ifg_timer.sv
// Inter-frame gap timer: counts cycles since the last restart, saturating at
// IFG_CYCLES; comes out of reset already elapsed.
module phy_tx_ifg_timer #(
   parameter int IFG_CYCLES = 600,
   parameter int CNT_W      = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic elapsed
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IFG_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             elapsed_q, elapsed_d;

   // Next count: clear on restart, otherwise count up and hold at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
      elapsed_d = (cnt_d == CNT_MAX);
   end

   // Counter and elapsed flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= CNT_MAX;
         elapsed_q <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         elapsed_q <= elapsed_d;
      end
   end

   assign elapsed = elapsed_q;

endmodule

// File: rtl/phy_tx_scheduler.sv
// PD PHY transmit scheduler: arbitrates reset/message/BIST requests, enforces
// the inter-frame gap and sequences the packet editor. BIST carrier mode is
// built only when PHY_TX_BIST_CARRIER_EN is defined.
module phy_tx_scheduler
   import pd_phy_pkg::*;
#(
   parameter int IFG_CYCLES = 600,
   parameter int CNT_W      = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   phy_tx_scheduler_if.slave  bus
);

   tx_state_e        state_q, state_d;
   logic [SOP_W-1:0] type_q, type_d;
   logic             pkt_en_q, pkt_en_d;
   logic             busy_q, busy_d;
   tx_pulse_t        pulse_q, pulse_d;
   logic             ifg_restart_s;
   logic             ifg_elapsed_s;
   logic             hard_req_s;
   logic             cable_req_s;
`ifdef PHY_TX_BIST_CARRIER_EN
   logic             bist_en_q, bist_en_d;
`endif

   assign hard_req_s  = bus.pl2phy_hard_reset_req;
   assign cable_req_s = bus.pl2phy_cable_reset_req;

   phy_tx_ifg_timer #(
      .IFG_CYCLES (IFG_CYCLES),
      .CNT_W      (CNT_W)
   ) u_ifg_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (ifg_restart_s),
      .elapsed (ifg_elapsed_s)
   );

   // Next-state, latched type and output pulse decode.
   always_comb begin
      state_d       = state_q;
      type_d        = type_q;
      pkt_en_d      = pkt_en_q;
      pulse_d       = '0;
      ifg_restart_s = 1'b0;
`ifdef PHY_TX_BIST_CARRIER_EN
      bist_en_d     = bist_en_q;
`endif
      case (state_q)
         TX_IDLE: begin
            pkt_en_d = 1'b0;
            if (hard_req_s) begin
               if (!bus.phy_rx_busy) begin
                  type_d  = SOP_TYPE_HARD_RESET;
                  state_d = TX_GAP;
               end else begin
                  state_d = TX_IDLE;
               end
            end else if (cable_req_s) begin
               if (!bus.phy_rx_busy) begin
                  type_d  = SOP_TYPE_CABLE_RESET;
                  state_d = TX_GAP;
               end else begin
                  state_d = TX_IDLE;
               end
            end else if (bus.pl2phy_tx_req) begin
               // A busy line means the message cannot go out: refuse it now.
               if (bus.phy_rx_busy) begin
                  pulse_d.discard = 1'b1;
               end else begin
                  type_d      = bus.pl2phy_tx_sop_type;
                  pulse_d.ack = 1'b1;
                  state_d     = TX_GAP;
               end
`ifdef PHY_TX_BIST_CARRIER_EN
            end else if (bus.pl2phy_bist_carrier_req) begin
               bist_en_d = 1'b1;
               state_d   = TX_BIST;
`endif
            end else begin
               state_d = TX_IDLE;
            end
         end
         TX_GAP: begin
            if (!is_reset_type(type_q) && (hard_req_s || cable_req_s)) begin
               pulse_d.discard = 1'b1;
               type_d = hard_req_s ? SOP_TYPE_HARD_RESET : SOP_TYPE_CABLE_RESET;
            end else if (ifg_elapsed_s) begin
               pkt_en_d = 1'b1;
               state_d  = TX_SEND;
            end else begin
               state_d = TX_GAP;
            end
         end
         TX_SEND: begin
            if (bus.phy_bmc_encoder_hold_lowbmc_done) begin
               pkt_en_d      = 1'b0;
               pulse_d       = done_pulse(type_q);
               ifg_restart_s = 1'b1;
               state_d       = TX_IDLE;
            end else begin
               pkt_en_d = 1'b1;
            end
         end
`ifdef PHY_TX_BIST_CARRIER_EN
         TX_BIST: begin
            if (bus.pl2phy_bist_carrier_req && !hard_req_s) begin
               bist_en_d = 1'b1;
            end else begin
               bist_en_d = 1'b0;
               state_d   = TX_BIST_STOP;
            end
         end
         TX_BIST_STOP: begin
            bist_en_d = 1'b0;
            if (bus.phy_bmc_encoder_data_done) begin
               ifg_restart_s = 1'b1;
               state_d       = TX_IDLE;
            end else begin
               state_d = TX_BIST_STOP;
            end
         end
`endif
         default: begin
            pkt_en_d = 1'b0;
            state_d  = TX_IDLE;
`ifdef PHY_TX_BIST_CARRIER_EN
            bist_en_d = 1'b0;
`endif
         end
      endcase
      busy_d = (state_d != TX_IDLE);
   end

   // State, latched type and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= TX_IDLE;
         type_q   <= '0;
         pkt_en_q <= 1'b0;
         busy_q   <= 1'b0;
         pulse_q  <= '0;
      end else begin
         state_q  <= state_d;
         type_q   <= type_d;
         pkt_en_q <= pkt_en_d;
         busy_q   <= busy_d;
         pulse_q  <= pulse_d;
      end
   end

`ifdef PHY_TX_BIST_CARRIER_EN
   // BIST carrier enable register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bist_en_q <= 1'b0;
      end else begin
         bist_en_q <= bist_en_d;
      end
   end

   assign bus.phy_tx_bist_en = bist_en_q;
`else
   assign bus.phy_tx_bist_en = 1'b0;
`endif

   assign bus.phy_tx_packet_en        = pkt_en_q;
   assign bus.phy_tx_packet_type      = type_q;
   assign bus.phy_tx_busy             = busy_q;
   assign bus.phy2pl_tx_ack           = pulse_q.ack;
   assign bus.phy2pl_tx_discard       = pulse_q.discard;
   assign bus.phy2pl_tx_done          = pulse_q.tx_done;
   assign bus.phy2pl_hard_reset_done  = pulse_q.hr_done;
   assign bus.phy2pl_cable_reset_done = pulse_q.cr_done;

endmodule
